palette_lut: RTL and testbench

//  Runtime-writable, multi-palette colour lookup for the VGA sprite path: maps a
//  4-bit sprite colour index plus palette select (team/player) to 12-bit RRRRGGGGBBBB.

---
 rtl/palette_lut.sv | 205 ++++++++++++++++++++
 tb/tb_palette_lut.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lut.sv
// Palette lookup: 4-bit sprite index + palette select -> 12-bit RGB, runtime writable, transparency flag.
// Latency: 2 cycles from pix_valid_in to pix_valid_out, one lookup per cycle, never stalls.
// Backpressure: none on lookups; writes accepted only when wr_ready=1 (after the default-load INIT walk).
//
// Ports: clk/rst (sync active-high); pix_valid_in/pix_idx/pal_sel -> pix_valid_out/rgb_out/transp_out;
//        wr_en/wr_pal/wr_idx/wr_data with wr_ready; frame_tick/flash_req drive the hit flash.
// Optional feature: define PALETTE_FLASH_EN to build the hit-flash counter.
module palette_lut #(
  parameter int                IDX_W        = 4,
  parameter int                RGB_W        = 12,
  parameter int                NUM_PAL      = 2,
  parameter int                PAL_W        = 1,
  parameter int                TRANSP_IDX   = 0,
  parameter logic [RGB_W-1:0]  ERR_COLOR    = RGB_W'(12'hF0F),
  parameter int                FLASH_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid_in,
  input  logic [IDX_W-1:0] pix_idx,
  input  logic [PAL_W-1:0] pal_sel,
  output logic             pix_valid_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             transp_out,
  input  logic             wr_en,
  input  logic [PAL_W-1:0] wr_pal,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [RGB_W-1:0] wr_data,
  output logic             wr_ready,
  input  logic             frame_tick,
  input  logic             flash_req
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int DEPTH   = NUM_PAL * ENTRIES;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic [RGB_W-1:0] mem_q [DEPTH];

  function automatic logic [AW-1:0] entry_addr(input int pal, input int idx);
    return AW'(pal * ENTRIES + idx);
  endfunction

  // Power-up colours; palette 1 only differs in entries 1 and 2.
  function automatic logic [RGB_W-1:0] default_color(input int addr);
    int pal;
    int idx;
    logic [RGB_W-1:0] c;
    pal = addr / ENTRIES;
    idx = addr % ENTRIES;
    c   = ERR_COLOR;
    case (idx)
      0: c = RGB_W'(12'h000);
      1: c = (pal == 1) ? RGB_W'(12'h8DF) : RGB_W'(12'hD42);
      2: c = (pal == 1) ? RGB_W'(12'h009) : RGB_W'(12'h921);
      3: c = RGB_W'(12'hFF9);
      4: c = RGB_W'(12'h210);
      5: c = RGB_W'(12'h778);
      6: c = RGB_W'(12'h6B4);
      7: c = RGB_W'(12'hDD0);
      8: c = RGB_W'(12'hFFF);
      default: c = ERR_COLOR;
    endcase
    return c;
  endfunction

  // ---------------- INIT / RUN control ----------------
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(DEPTH - 1)) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign wr_ready = (state_q == ST_RUN);

  // ---------------- palette storage ----------------
  logic wr_acc;
  assign wr_acc = wr_en && wr_ready && (int'(wr_pal) < NUM_PAL);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_q[init_cnt_q] <= default_color(int'(init_cnt_q));
      end else if (wr_acc) begin
        mem_q[entry_addr(int'(wr_pal), int'(wr_idx))] <= wr_data;
      end
    end
  end

  // The RAM is read in the request cycle, so a write landing on the same edge is
  // not yet visible (old data); any later request sees the new colour.
  logic             req_pal_ok;
  logic [RGB_W-1:0] rd_dat;
  assign req_pal_ok = (int'(pal_sel) < NUM_PAL);
  assign rd_dat     = req_pal_ok ? mem_q[entry_addr(int'(pal_sel), int'(pix_idx))] : '0;

  // ---------------- stage 1 ----------------
  logic             s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_pal_ok_q;
  logic [RGB_W-1:0] s1_dat_q;

  // Lookups are only honoured once the defaults are loaded.
  assign s1_vld_d = pix_valid_in && wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_pal_ok_q <= 1'b0;
      s1_dat_q    <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_idx_q    <= pix_idx;
      s1_pal_ok_q <= req_pal_ok;
      s1_dat_q    <= rd_dat;
    end
  end

  // ---------------- hit flash ----------------
  logic flash_on;
`ifdef PALETTE_FLASH_EN
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (flash_req && wr_ready) begin
      flash_cnt_d = FW'(FLASH_FRAMES);
    end else if (frame_tick && (flash_cnt_q != '0)) begin
      flash_cnt_d = flash_cnt_q - FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flash_cnt_q <= '0;
    else     flash_cnt_q <= flash_cnt_d;
  end

  // Odd count implies non-zero: white on alternating frames.
  assign flash_on = flash_cnt_q[0];
`else
  logic unused_flash;
  assign unused_flash = ^{flash_req, frame_tick, (FLASH_FRAMES > 0)};
  assign flash_on     = 1'b0;
`endif

  // ---------------- stage 2 / outputs ----------------
  logic             vld_q, vld_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             transp_q, transp_d;

  always_comb begin
    vld_d    = s1_vld_q;
    rgb_d    = '0;
    transp_d = 1'b0;
    if (s1_vld_q) begin
      if (s1_idx_q == IDX_W'(TRANSP_IDX)) transp_d = 1'b1;
      else if (flash_on)                  rgb_d    = {RGB_W{1'b1}};
      else if (!s1_pal_ok_q)              rgb_d    = ERR_COLOR;
      else                                rgb_d    = s1_dat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= 1'b0;
      rgb_q    <= '0;
      transp_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      rgb_q    <= rgb_d;
      transp_q <= transp_d;
    end
  end

  assign pix_valid_out = vld_q;
  assign rgb_out       = rgb_q;
  assign transp_out    = transp_q;

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: a 2-palette DUT and a 1-palette DUT share all inputs.
module tb_palette_lut;
  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid_in;
  logic [3:0]  pix_idx;
  logic [0:0]  pal_sel;
  logic        wr_en;
  logic [0:0]  wr_pal;
  logic [3:0]  wr_idx;
  logic [11:0] wr_data;
  logic        frame_tick;
  logic        flash_req;

  logic        pix_valid_out, transp_out, wr_ready;
  logic [11:0] rgb_out;
  logic        one_valid, one_transp, one_ready;
  logic [11:0] one_rgb;

  int checks = 0;
  int errors = 0;

  palette_lut u_dut (
    .clk(clk), .rst(rst), .pix_valid_in(pix_valid_in), .pix_idx(pix_idx), .pal_sel(pal_sel),
    .pix_valid_out(pix_valid_out), .rgb_out(rgb_out), .transp_out(transp_out),
    .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ready(wr_ready),
    .frame_tick(frame_tick), .flash_req(flash_req)
  );

  palette_lut #(.NUM_PAL(1)) u_one (
    .clk(clk), .rst(rst), .pix_valid_in(pix_valid_in), .pix_idx(pix_idx), .pal_sel(pal_sel),
    .pix_valid_out(one_valid), .rgb_out(one_rgb), .transp_out(one_transp),
    .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ready(one_ready),
    .frame_tick(frame_tick), .flash_req(flash_req)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Advance one clock; inputs change and outputs are observed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid_in = 1'b0; pix_idx = '0; pal_sel = '0;
    wr_en = 1'b0; wr_pal = '0; wr_idx = '0; wr_data = '0; frame_tick = 1'b0; flash_req = 1'b0;
    step();
    checks++;
    if ({pix_valid_out, rgb_out, transp_out, wr_ready} !== 15'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rgb=%h t=%b rdy=%b, expected all 0",
               pix_valid_out, rgb_out, transp_out, wr_ready);
    end
    rst = 1'b0; pix_valid_in = 1'b1; pal_sel = 1'd0; pix_idx = 4'd1;
    for (int k = 1; k <= 33; k++) begin
      step();
      checks++;
      if (pix_valid_out !== 1'b0) begin
        errors++;
        $display("FAIL init_valid cycle %0d: got %b expected 0", k, pix_valid_out);
      end
      checks++;
      if (wr_ready !== (k >= 32)) begin
        errors++;
        $display("FAIL init_wr_ready cycle %0d: got %b expected %b", k, wr_ready, (k >= 32));
      end
    end
    step();
    checks++;
    if ({pix_valid_out, rgb_out, transp_out} !== {1'b1, 12'hD42, 1'b0}) begin
      errors++;
      $display("FAIL first_lookup: got v=%b rgb=%h t=%b expected v=1 rgb=d42 t=0",
               pix_valid_out, rgb_out, transp_out);
    end
    pix_valid_in = 1'b0;
    step();
    step();
  endtask

  task automatic test_lookups();
    logic [0:0]  tp [8] = '{1'd1, 1'd1, 1'd0, 1'd0, 1'd1, 1'd0, 1'd1, 1'd0};
    logic [3:0]  ti [8] = '{4'd1, 4'd2, 4'd8, 4'd12, 4'd12, 4'd0, 4'd0, 4'd3};
    logic [11:0] te [8] = '{12'h8DF, 12'h009, 12'hFFF, 12'hF0F, 12'hF0F, 12'h000, 12'h000, 12'hFF9};
    logic        tt [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [11:0] one_exp;
    for (int n = 0; n < 8; n++) begin
      pal_sel = tp[n]; pix_idx = ti[n]; pix_valid_in = 1'b1;
      step();
      pix_valid_in = 1'b0;
      step();
      checks++;
      if ({pix_valid_out, rgb_out, transp_out} !== {1'b1, te[n], tt[n]}) begin
        errors++;
        $display("FAIL lookup pal%0d idx%0d: got v=%b rgb=%h t=%b expected v=1 rgb=%h t=%b",
                 tp[n], ti[n], pix_valid_out, rgb_out, transp_out, te[n], tt[n]);
      end
      one_exp = (tp[n] == 1'd1 && !tt[n]) ? 12'hF0F : te[n];
      checks++;
      if ({one_valid, one_rgb, one_transp} !== {1'b1, one_exp, tt[n]}) begin
        errors++;
        $display("FAIL one_pal_lookup pal%0d idx%0d: got v=%b rgb=%h t=%b expected v=1 rgb=%h t=%b",
                 tp[n], ti[n], one_valid, one_rgb, one_transp, one_exp, tt[n]);
      end
    end
    step();
    checks++;
    if ({pix_valid_out, rgb_out, transp_out} !== 14'b0) begin
      errors++;
      $display("FAIL idle_zero: got v=%b rgb=%h t=%b expected all 0", pix_valid_out, rgb_out, transp_out);
    end
  endtask

  task automatic test_write_collision();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_wr_ready: got %b expected 1", wr_ready);
    end
    wr_en = 1'b1; wr_pal = 1'd0; wr_idx = 4'd3; wr_data = 12'h0A5;
    pix_valid_in = 1'b1; pal_sel = 1'd0; pix_idx = 4'd3;
    step();
    wr_en = 1'b0;
    step();
    checks++;
    if (rgb_out !== 12'hFF9 || one_rgb !== 12'hFF9) begin
      errors++;
      $display("FAIL collision_old: got %h/%h expected ff9", rgb_out, one_rgb);
    end
    pix_valid_in = 1'b0;
    step();
    checks++;
    if (rgb_out !== 12'h0A5 || one_rgb !== 12'h0A5) begin
      errors++;
      $display("FAIL after_write_new: got %h/%h expected 0a5", rgb_out, one_rgb);
    end
    // Palette 1 write: lands in the 2-palette DUT, must be dropped by the 1-palette one.
    wr_en = 1'b1; wr_pal = 1'd1; wr_idx = 4'd5; wr_data = 12'h123;
    step();
    wr_en = 1'b0; pix_valid_in = 1'b1; pal_sel = 1'd1; pix_idx = 4'd5;
    step();
    pal_sel = 1'd0;
    step();
    checks++;
    if (rgb_out !== 12'h123) begin
      errors++;
      $display("FAIL pal1_write: got %h expected 123", rgb_out);
    end
    pix_valid_in = 1'b0;
    step();
    checks++;
    if (rgb_out !== 12'h778 || one_rgb !== 12'h778) begin
      errors++;
      $display("FAIL dropped_write_pal0: got %h/%h expected 778", rgb_out, one_rgb);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] tbl [16] = '{12'h000, 12'hD42, 12'h921, 12'h0A5, 12'h210, 12'h778, 12'h6B4, 12'hDD0,
                              12'hFFF, 12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F};
    step();
    pal_sel = 1'd0;
    for (int j = 0; j < 18; j++) begin
      if (j < 16) begin
        pix_valid_in = 1'b1; pix_idx = 4'(j);
      end else begin
        pix_valid_in = 1'b0;
      end
      step();
      checks++;
      if (j >= 1 && j <= 16) begin
        if ({pix_valid_out, rgb_out, transp_out} !== {1'b1, tbl[j-1], (j == 1)}) begin
          errors++;
          $display("FAIL stream idx%0d: got v=%b rgb=%h t=%b expected v=1 rgb=%h t=%b",
                   j - 1, pix_valid_out, rgb_out, transp_out, tbl[j-1], (j == 1));
        end
      end else if (pix_valid_out !== 1'b0) begin
        errors++;
        $display("FAIL stream_edge cycle %0d: got v=%b expected 0", j, pix_valid_out);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    pix_valid_in = 1'b1; pal_sel = 1'd0; pix_idx = 4'd1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({pix_valid_out, wr_ready, one_valid, one_ready} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rdy=%b one_v=%b one_rdy=%b expected 0",
               pix_valid_out, wr_ready, one_valid, one_ready);
    end
    for (int k = 1; k <= 33; k++) begin
      step();
      checks++;
      if (pix_valid_out !== 1'b0 || wr_ready !== (k >= 32)) begin
        errors++;
        $display("FAIL reinit cycle %0d: got v=%b rdy=%b expected v=0 rdy=%b",
                 k, pix_valid_out, wr_ready, (k >= 32));
      end
    end
    pix_idx = 4'd3;
    step();
    checks++;
    if ({pix_valid_out, rgb_out} !== {1'b1, 12'hD42}) begin
      errors++;
      $display("FAIL reinit_first: got v=%b rgb=%h expected v=1 rgb=d42", pix_valid_out, rgb_out);
    end
    pal_sel = 1'd1; pix_idx = 4'd5;
    step();
    checks++;
    if (rgb_out !== 12'hFF9) begin
      errors++;
      $display("FAIL default_restored_pal0_idx3: got %h expected ff9", rgb_out);
    end
    pix_valid_in = 1'b0;
    step();
    checks++;
    if (rgb_out !== 12'h778) begin
      errors++;
      $display("FAIL default_restored_pal1_idx5: got %h expected 778", rgb_out);
    end
  endtask

  task automatic test_flash();
    logic [11:0] exp;
    pal_sel = 1'd0;
    flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    for (int f = 1; f <= 9; f++) begin
`ifdef PALETTE_FLASH_EN
      exp = ((f % 2 == 0) && f <= 8) ? 12'hFFF : 12'hD42;
`else
      exp = 12'hD42;
`endif
      pix_valid_in = 1'b1; pix_idx = 4'd1;
      step();
      pix_idx = 4'd0;
      step();
      checks++;
      if (rgb_out !== exp) begin
        errors++;
        $display("FAIL flash_frame%0d idx1: got %h expected %h", f, rgb_out, exp);
      end
      pix_valid_in = 1'b0;
      step();
      checks++;
      if ({transp_out, rgb_out} !== {1'b1, 12'h000}) begin
        errors++;
        $display("FAIL flash_frame%0d idx0: got t=%b rgb=%h expected t=1 rgb=000", f, transp_out, rgb_out);
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_lookups();
    test_write_collision();
    test_back_to_back();
    test_reset_mid_stream();
    test_flash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
